dyn_delay_line: RTL and testbench
=================================

Name: dyn_delay_line

Overview:
- Parametrised, runtime-programmable successor to the fixed-length 30/45/60/90-tap delay lines.
- One circular buffer of MAX_DEPTH words replaces per-length shift chains. Delay length is loadable at run time.
- Samples advance only on an input strobe. An output-valid level and a fill counter mask stale data after reset, reload or clear.
- Sits between the pad inputs and the output mux of the top-level tile. One instance serves every delay setting.

Parameters:
- WIDTH, 8, data word width in bits.
- MAX_DEPTH, 128, maximum delay in accepted samples; ≥2; buffer depth.
- DEFAULT_DELAY, 30, delay after reset; 1..MAX_DEPTH.
- Derived localparams: PTR_W = clog2(MAX_DEPTH); DLY_W = clog2(MAX_DEPTH+1).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  accept data_in this cycle and advance the line.
- data_in  in  WIDTH  input sample.
- delay_load  in  1  latch delay_in as the new delay and restart fill.
- delay_in  in  DLY_W  requested delay, clamped to 1..MAX_DEPTH.
- clear  in  1  synchronous flush; keeps the current delay.
- data_out  out  WIDTH  delayed sample; 0 while not valid.
- out_stb  out  1  one-cycle pulse: data_out/out_valid updated for an accepted sample.
- out_valid  out  1  level; the line holds ≥ delay_cur samples since the last fill restart.
- delay_cur  out  DLY_W  active delay.
- fill_count  out  DLY_W  accepted samples since restart, saturating at delay_cur.

Behaviour:
- Reset (async, active-high) values:
  - wr_ptr=0, fill_count=0, delay_cur=DEFAULT_DELAY.
  - data_out=0, out_valid=0, out_stb=0.
  - Storage array is not reset; stale contents are masked by fill logic.
- Storage and pointers:
  - mem[0..MAX_DEPTH-1].
  - rd_addr = (wr_ptr − delay_cur) mod MAX_DEPTH.
  - Read-before-write: with delay_cur=MAX_DEPTH, rd_addr==wr_ptr returns the old word.
- Accepted sample (in_valid=1, clear=0), on the clock edge:
  - mem[wr_ptr] <= data_in.
  - wr_ptr wraps MAX_DEPTH−1 → 0.
  - out_stb <= 1.
  - If fill_count==delay_cur (pre-update): data_out <= mem[rd_addr] and out_valid <= 1. Otherwise data_out <= 0 and out_valid <= 0.
  - fill_count <= min(fill_count+1, delay_cur).
- Result: for the k-th accepted sample (k from 0), data_out = sample[k−D] when k ≥ D, else 0. Latency is one clock from the in_valid edge to out_stb.
- No in_valid: data_out, out_valid and fill_count hold; out_stb=0.
- Delay clamp: delay_in=0 → 1; delay_in>MAX_DEPTH → MAX_DEPTH.
- delay_load:
  - delay_cur <= clamp(delay_in).
  - fill_count <= (in_valid ? 1 : 0).
  - data_out <= 0, out_valid <= 0.
  - A simultaneous in_valid sample is written and counted under the new delay; out_stb still pulses.
- clear:
  - wr_ptr <= 0, fill_count <= 0, data_out <= 0, out_valid <= 0, out_stb <= 0.
  - delay_cur unchanged; in_valid and delay_load ignored that cycle.
- Priority: reset > clear > delay_load > in_valid.
- Reset mid-stream: outputs go to reset values immediately (asynchronously). The first D accepted samples after release produce 0 with out_valid=0.
- Reducing delay via load never exposes samples older than the restart point, because the fill counter forces a full refill.

Decomposition:
- Package delay_line_pkg holds:
  - clog2 constant function.
  - Default constants: DL_WIDTH=8, DL_MAX_DEPTH=128, DL_DEFAULT_DELAY=30.
  - Top-level delay-select encodings: 0→30, 1→45, 2→60, 3→90.
- Sub-module delay_ring_mem: WIDTH × MAX_DEPTH array with one write port and one asynchronous read port, read-before-write semantics. Pointer, fill and control logic stay in dyn_delay_line.

Test Plan:
- Fill and steady state (MAX_DEPTH=8, DEFAULT_DELAY=3). Stream 1..6 with in_valid every cycle:
  - Expected data_out 0,0,0,1,2,3.
  - out_valid rises with the 4th out_stb; fill_count saturates at 3.
- Maximum delay and wrap. Load delay_in=8, then stream 1..20:
  - Output k = sample k−8 across pointer wrap; first valid output is 1 on the 9th strobe.
- Clamp and load:
  - delay_in=0 → delay_cur=1; delay_in=200 (MAX 128) → delay_cur=128.
  - Load 2 mid-stream with simultaneous in_valid: data_out=0 and out_valid=0 for the next strobe, then sample[k−2]; fill_count=1 after the load cycle.
- Gapped input. in_valid every 3rd cycle, D=2:
  - data_out holds between strobes.
  - Output sequence equals the D=2 continuous case; out_stb is high only one cycle after each strobe.
- Clear vs load collision. clear, delay_load and in_valid all high:
  - delay_cur unchanged, wr_ptr=0, out_valid=0.
  - The sample is not written; the next D samples output 0.
- Async reset mid-stream at an off-edge time:
  - All outputs go to 0 and delay_cur to DEFAULT_DELAY before the next clock edge.
  - Refill behaves as in the first scenario.

Source files
------------

// File: rtl/dyn_delay_line_pkg.sv
// Shared constants and helpers for the runtime-programmable delay line.
// Holds the clog2 sizing function, the default build constants, and the
// legacy delay-select encoding used by the tile's output mux (0..3 -> 30/45/60/90).
package delay_line_pkg;

    localparam int DL_WIDTH         = 8;
    localparam int DL_MAX_DEPTH     = 128;
    localparam int DL_DEFAULT_DELAY = 30;

    // Smallest r with 2**r >= value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    typedef enum logic [1:0] {
        DSEL_30 = 2'd0,
        DSEL_45 = 2'd1,
        DSEL_60 = 2'd2,
        DSEL_90 = 2'd3
    } dly_sel_e;

    function automatic int dsel_to_delay(input dly_sel_e sel);
        case (sel)
            DSEL_30: return 30;
            DSEL_45: return 45;
            DSEL_60: return 60;
            default: return 90;
        endcase
    endfunction

endpackage

// File: rtl/dyn_delay_line_if.sv
// Control/data bundle for dyn_delay_line.
//   master : drives in_valid, data_in, delay_load, delay_in, clear
//            and observes data_out, out_stb, out_valid, delay_cur, fill_count
//   slave  : the delay line itself (mirror image)
// DLY_W must match clog2(MAX_DEPTH+1) of the attached delay line.
interface dyn_delay_line_if
    import delay_line_pkg::*;
#(
    parameter int WIDTH = DL_WIDTH,
    parameter int DLY_W = clog2(DL_MAX_DEPTH + 1)
) ();
    logic             in_valid;
    logic [WIDTH-1:0] data_in;
    logic             delay_load;
    logic [DLY_W-1:0] delay_in;
    logic             clear;
    logic [WIDTH-1:0] data_out;
    logic             out_stb;
    logic             out_valid;
    logic [DLY_W-1:0] delay_cur;
    logic [DLY_W-1:0] fill_count;

    modport master (
        output in_valid, data_in, delay_load, delay_in, clear,
        input  data_out, out_stb, out_valid, delay_cur, fill_count
    );

    modport slave (
        input  in_valid, data_in, delay_load, delay_in, clear,
        output data_out, out_stb, out_valid, delay_cur, fill_count
    );
endinterface

// File: rtl/dyn_delay_line_ring_mem.sv
// Circular sample store: one synchronous write port and one asynchronous
// read port. Reading the address being written in the same cycle returns the
// old word, which is what the full-depth delay relies on.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : combinational read data
// Contents are intentionally not reset.
module delay_ring_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/dyn_delay_line.sv
// Runtime-programmable delay line built on a single circular buffer.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : dyn_delay_line_if.slave
//           in_valid/data_in   accept and store a sample, advance the line
//           delay_load/delay_in load a new (clamped) delay and restart fill
//           clear              flush pointer/fill/outputs, keep delay
//           data_out/out_valid delayed sample (0 when not valid)
//           out_stb            one-cycle pulse per accepted sample
//           delay_cur/fill_count active delay and samples since restart
// Priority: reset > clear > delay_load > in_valid.
module dyn_delay_line
    import delay_line_pkg::*;
#(
    parameter int WIDTH         = DL_WIDTH,
    parameter int MAX_DEPTH     = DL_MAX_DEPTH,
    parameter int DEFAULT_DELAY = DL_DEFAULT_DELAY
) (
    input logic              clock,
    input logic              reset,
    dyn_delay_line_if.slave  bus
);
    localparam int PTR_W = clog2(MAX_DEPTH);
    localparam int DLY_W = clog2(MAX_DEPTH + 1);
    localparam logic [DLY_W:0] MAX_EXT = (DLY_W+1)'(MAX_DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [DLY_W-1:0] r_fill;
    logic [DLY_W-1:0] r_delay;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_stb;

    logic             w_accept;
    logic [PTR_W-1:0] w_ptr_next;
    logic [DLY_W:0]   w_rd_full;
    logic [DLY_W:0]   w_rd_wrap;
    logic [PTR_W-1:0] w_rd_addr;
    logic [DLY_W-1:0] w_dly_clamp;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_full;

    assign w_accept   = bus.in_valid & ~bus.clear;
    assign w_ptr_next = (r_wr_ptr == PTR_W'(MAX_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;

    // (wr_ptr - delay) mod MAX_DEPTH without assuming a power-of-two depth:
    // bias by MAX_DEPTH so the subtraction never goes negative, then fold once.
    assign w_rd_full = (DLY_W+1)'(r_wr_ptr) + MAX_EXT - {1'b0, r_delay};
    assign w_rd_wrap = (w_rd_full >= MAX_EXT) ? w_rd_full - MAX_EXT : w_rd_full;
    assign w_rd_addr = PTR_W'(w_rd_wrap);

    assign w_dly_clamp = (bus.delay_in == '0)                 ? DLY_W'(1)         :
                         (bus.delay_in > DLY_W'(MAX_DEPTH))   ? DLY_W'(MAX_DEPTH) :
                                                                bus.delay_in;

    // Line holds a full delay's worth of samples since the last restart.
    assign w_full = (r_fill == r_delay);

    delay_ring_mem #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .i_clk   (clock),
        .i_we    (w_accept),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.data_in),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_delay  <= DLY_W'(DEFAULT_DELAY);
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_stb    <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_stb    <= 1'b0;
        end else if (bus.delay_load) begin
            // A coincident sample is the first one counted under the new delay.
            r_delay <= w_dly_clamp;
            r_fill  <= bus.in_valid ? DLY_W'(1) : '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_stb   <= bus.in_valid;
            if (bus.in_valid) r_wr_ptr <= w_ptr_next;
        end else if (bus.in_valid) begin
            r_wr_ptr <= w_ptr_next;
            r_stb    <= 1'b1;
            r_data   <= w_full ? w_rd_data : '0;
            r_valid  <= w_full;
            r_fill   <= w_full ? r_delay : r_fill + 1'b1;
        end else begin
            r_stb <= 1'b0;
        end
    end

    assign bus.data_out   = r_data;
    assign bus.out_stb    = r_stb;
    assign bus.out_valid  = r_valid;
    assign bus.delay_cur  = r_delay;
    assign bus.fill_count = r_fill;
endmodule

// File: tb/tb_dyn_delay_line.sv
// Randomized scoreboard bench for dyn_delay_line (MAX_DEPTH=8, DEFAULT_DELAY=3)
// plus a default-parameter instance for the wide clamp cases.
module tb_dyn_delay_line;
    import delay_line_pkg::*;

    localparam int W   = 8;
    localparam int MAXD = 8;
    localparam int DEF = 3;
    localparam int DW  = clog2(MAXD + 1);
    localparam int DW2 = clog2(DL_MAX_DEPTH + 1);

    typedef struct {
        int data;
        int valid;
        int fill;
    } exp_t;

    logic clk;
    logic rst;

    dyn_delay_line_if #(.WIDTH(W), .DLY_W(DW))  bus1 ();
    dyn_delay_line_if #(.WIDTH(W), .DLY_W(DW2)) bus2 ();

    dyn_delay_line #(.WIDTH(W), .MAX_DEPTH(MAXD), .DEFAULT_DELAY(DEF)) dut1 (
        .clock (clk),
        .reset (rst),
        .bus   (bus1.slave)
    );

    dyn_delay_line dut2 (
        .clock (clk),
        .reset (rst),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t expq[$];

    // Reference model: the samples accepted since the last restart, and the delay.
    int   hist[$];
    int   m_delay = DEF;
    int   last_data = 0;
    int   last_valid = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampd(input int d);
        if (d == 0) return 1;
        if (d > MAXD) return MAXD;
        return d;
    endfunction

    function automatic void model(input bit v, input int d, input bit ld, input int din, input bit clr);
        exp_t e;
        int   k;
        if (clr) begin
            hist.delete();
            last_data = 0;
            last_valid = 0;
            return;
        end
        if (ld) begin
            m_delay = clampd(din);
            hist.delete();
            last_data = 0;
            last_valid = 0;
            if (v) begin
                hist.push_back(d);
                e.data = 0; e.valid = 0; e.fill = 1;
                expq.push_back(e);
            end
            return;
        end
        if (v) begin
            k = hist.size();
            e.valid = (k >= m_delay) ? 1 : 0;
            e.data  = e.valid ? hist[k - m_delay] : 0;
            e.fill  = (k + 1 < m_delay) ? k + 1 : m_delay;
            hist.push_back(d);
            expq.push_back(e);
            last_data = e.data;
            last_valid = e.valid;
        end
    endfunction

    // Called at posedge+1; applies inputs across one rising edge.
    task automatic step(input bit v, input int d, input bit ld, input int din, input bit clr);
        bus1.in_valid   = v;
        bus1.data_in    = W'(d);
        bus1.delay_load = ld;
        bus1.delay_in   = DW'(din);
        bus1.clear      = clr;
        model(v, d, ld, din, clr);
        @(posedge clk);
        #1;
        bus1.in_valid   = 1'b0;
        bus1.delay_load = 1'b0;
        bus1.clear      = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus1.out_stb) begin
                if (expq.size() == 0) begin
                    chk("stb_unexpected", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("data_out", int'(bus1.data_out), e.data);
                    chk("out_valid", int'(bus1.out_valid), e.valid);
                    chk("fill_count", int'(bus1.fill_count), e.fill);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        bit v, ld, clr;
        rst = 1'b1;
        bus1.in_valid = 0; bus1.data_in = '0; bus1.delay_load = 0; bus1.delay_in = '0; bus1.clear = 0;
        bus2.in_valid = 0; bus2.data_in = '0; bus2.delay_load = 0; bus2.delay_in = '0; bus2.clear = 0;
        #12;
        chk("rst_data_out", int'(bus1.data_out), 0);
        chk("rst_out_valid", int'(bus1.out_valid), 0);
        chk("rst_out_stb", int'(bus1.out_stb), 0);
        chk("rst_fill", int'(bus1.fill_count), 0);
        chk("rst_delay_cur", int'(bus1.delay_cur), DEF);
        chk("rst_delay_cur2", int'(bus2.delay_cur), DL_DEFAULT_DELAY);
        rst = 1'b0;
        @(posedge clk); #1;

        // Wide clamp on the default-size instance.
        bus2.delay_load = 1; bus2.delay_in = 8'd200;
        @(posedge clk); #1;
        chk("clamp200", int'(bus2.delay_cur), DL_MAX_DEPTH);
        bus2.delay_in = 8'd0;
        @(posedge clk); #1;
        chk("clamp0_wide", int'(bus2.delay_cur), 1);
        bus2.delay_load = 0;

        // Fill and steady state, D=3.
        for (int i = 1; i <= 6; i++) step(1, i, 0, 0, 0);
        chk("fill_sat", int'(bus1.fill_count), 3);

        // Full depth across pointer wrap.
        step(0, 0, 1, 8, 0);
        chk("delay_max", int'(bus1.delay_cur), 8);
        for (int i = 1; i <= 20; i++) step(1, i, 0, 0, 0);

        // Clamp, then a mid-stream load with a coincident sample.
        step(0, 0, 1, 0, 0);
        chk("clamp0", int'(bus1.delay_cur), 1);
        step(0, 0, 1, 15, 0);
        chk("clamp15", int'(bus1.delay_cur), MAXD);
        step(0, 0, 1, 3, 0);
        for (int i = 0; i < 6; i++) step(1, $urandom_range(0, 255), 0, 0, 0);
        step(1, $urandom_range(0, 255), 1, 2, 0);
        chk("load_fill", int'(bus1.fill_count), 1);
        for (int i = 0; i < 6; i++) step(1, $urandom_range(0, 255), 0, 0, 0);

        // Gapped input, D=2: outputs hold between strobes.
        step(0, 0, 1, 2, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, $urandom_range(0, 255), 0, 0, 0);
            for (int j = 0; j < 2; j++) begin
                step(0, 0, 0, 0, 0);
                chk("hold_data", int'(bus1.data_out), last_data);
                chk("hold_valid", int'(bus1.out_valid), last_valid);
                chk("gap_stb_low", int'(bus1.out_stb), 0);
            end
        end

        // clear + delay_load + in_valid together: clear wins.
        step(1, 8'hAA, 1, 5, 1);
        chk("coll_delay", int'(bus1.delay_cur), m_delay);
        chk("coll_valid", int'(bus1.out_valid), 0);
        chk("coll_stb", int'(bus1.out_stb), 0);
        chk("coll_fill", int'(bus1.fill_count), 0);
        for (int i = 0; i < 5; i++) step(1, $urandom_range(0, 255), 0, 0, 0);

        // Random traffic with occasional loads and clears.
        for (int i = 0; i < 300; i++) begin
            r   = int'($urandom_range(0, 99));
            clr = (r < 3);
            ld  = (r >= 3 && r < 9);
            v   = ($urandom_range(0, 3) != 0);
            step(v, $urandom_range(0, 255), ld, $urandom_range(0, 15), clr);
        end
        chk("rand_delay", int'(bus1.delay_cur), m_delay);

        // Async reset between edges while streaming.
        step(0, 0, 1, 5, 0);
        for (int i = 0; i < 7; i++) step(1, $urandom_range(0, 255), 0, 0, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_data", int'(bus1.data_out), 0);
        chk("arst_valid", int'(bus1.out_valid), 0);
        chk("arst_stb", int'(bus1.out_stb), 0);
        chk("arst_fill", int'(bus1.fill_count), 0);
        chk("arst_delay", int'(bus1.delay_cur), DEF);
        hist.delete();
        m_delay = DEF;
        last_data = 0;
        last_valid = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) step(1, i, 0, 0, 0);
        chk("arst_refill_sat", int'(bus1.fill_count), 3);

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("pending_expect", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
